// File: rtl/debug_reg_scanner_pkg.sv
// Shared types and constants for the debug register scanner: FSM state
// encoding and the register-file geometry of the debug select mux.
package debug_reg_scanner_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SEND,
        ST_ENDF
    } scan_state_e;

endpackage

// File: rtl/debug_out_stage.sv
// Single-entry output register: captures an {addr, data} pair on load and
// holds it stable until the consumer accepts it.
module debug_out_stage
    import debug_reg_scanner_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  ready_i,
    input  logic [REG_ADDR_W-1:0] addr_i,
    input  logic [REG_DATA_W-1:0] data_i,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] addr_o,
    output logic [REG_DATA_W-1:0] data_o
);

    logic                  valid_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic [REG_DATA_W-1:0] data_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/debug_reg_scanner.sv
// Walks a register address range through the debug select mux, lets the
// mux output settle, captures each word and streams {addr, data} pairs.
module debug_reg_scanner
    import debug_reg_scanner_pkg::*;
#(
    parameter int FIRST_ADDR    = 0,
    parameter int LAST_ADDR     = 31,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    output logic [REG_ADDR_W-1:0] debug_addr,
    input  logic [REG_DATA_W-1:0] debug_data_reg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_addr,
    output logic [REG_DATA_W-1:0] out_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_count
);

    localparam logic [REG_ADDR_W-1:0] FIRST_A     = FIRST_ADDR[REG_ADDR_W-1:0];
    localparam logic [REG_ADDR_W-1:0] LAST_A      = LAST_ADDR[REG_ADDR_W-1:0];
    localparam logic [3:0]            SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    scan_state_e           state_q;
    logic [REG_ADDR_W-1:0] cur_addr_q;
    logic [REG_ADDR_W-1:0] debug_addr_q;
    logic [3:0]            settle_cnt_q;
    logic                  busy_q;
    logic                  frame_done_q;
    logic [15:0]           frame_count_q;

    // debug_addr is only rewritten on entry to SETTLE (or back to IDLE), so the
    // mux input stays stable from SETTLE through CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cur_addr_q    <= FIRST_A;
            debug_addr_q  <= FIRST_A;
            settle_cnt_q  <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_SETTLE;
                        cur_addr_q   <= FIRST_A;
                        debug_addr_q <= FIRST_A;
                        settle_cnt_q <= '0;
                        busy_q       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt_q <= settle_cnt_q + 4'd1;
                    if (settle_cnt_q == SETTLE_LAST) state_q <= ST_CAPTURE;
                end
                ST_CAPTURE: state_q <= ST_SEND;
                ST_SEND: begin
                    if (out_valid && out_ready) begin
                        if (cur_addr_q == LAST_A) begin
                            state_q       <= ST_ENDF;
                            frame_done_q  <= 1'b1;
                            frame_count_q <= frame_count_q + 16'd1;
                        end else begin
                            state_q      <= ST_SETTLE;
                            cur_addr_q   <= cur_addr_q + 5'd1;
                            debug_addr_q <= cur_addr_q + 5'd1;
                            settle_cnt_q <= '0;
                        end
                    end
                end
                ST_ENDF: begin
                    cur_addr_q   <= FIRST_A;
                    debug_addr_q <= FIRST_A;
                    settle_cnt_q <= '0;
                    if (continuous) begin
                        state_q <= ST_SETTLE;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    debug_out_stage u_out_stage (
        .clk     (clk),
        .rst     (rst),
        .load_i  (state_q == ST_CAPTURE),
        .ready_i (out_ready),
        .addr_i  (cur_addr_q),
        .data_i  (debug_data_reg),
        .valid_o (out_valid),
        .addr_o  (out_addr),
        .data_o  (out_data)
    );

    assign debug_addr  = debug_addr_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_debug_reg_scanner.sv
// Scoreboard bench for debug_reg_scanner: a mux model feeds register words,
// expected pairs are queued at frame start and popped by an output monitor.
module tb_debug_reg_scanner;
    import debug_reg_scanner_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, continuous, out_ready;
    logic [4:0]  debug_addr, out_addr;
    logic [31:0] debug_data_reg, out_data;
    logic        out_valid, busy, frame_done;
    logic [15:0] frame_count;

    logic        c_start, c_cont, c_ready;
    logic [4:0]  c_debug_addr, c_out_addr;
    logic [31:0] c_debug_data, c_out_data;
    logic        c_out_valid, c_busy, c_frame_done;
    logic [15:0] c_frame_count;

    int total = 0;
    int bad   = 0;
    int exp_fc;
    logic [36:0] exp_q[$];
    logic [36:0] exp_pair;

    function automatic logic [31:0] mux_word(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : (32'h1000_0000 | {27'd0, a});
    endfunction

    assign debug_data_reg = mux_word(debug_addr);
    assign c_debug_data   = mux_word(c_debug_addr);

    debug_reg_scanner dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .debug_addr(debug_addr), .debug_data_reg(debug_data_reg),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count)
    );

    debug_reg_scanner #(.FIRST_ADDR(7), .LAST_ADDR(7), .SETTLE_CYCLES(4)) dut_c (
        .clk(clk), .rst(rst), .start(c_start), .continuous(c_cont),
        .debug_addr(c_debug_addr), .debug_data_reg(c_debug_data),
        .out_valid(c_out_valid), .out_ready(c_ready), .out_addr(c_out_addr),
        .out_data(c_out_data), .busy(c_busy), .frame_done(c_frame_done),
        .frame_count(c_frame_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_frame();
        for (int a = 0; a < 32; a++) exp_q.push_back({5'(a), mux_word(5'(a))});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic wait_pair(input logic [4:0] a, input string name);
        int n;
        n = 0;
        while (!(out_valid && out_addr == a) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, {out_valid, out_addr}, {1'b1, a});
    endtask

    // Monitor: every accepted pair is checked against the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pair_unexpected: got addr=%0d data=0x%0h expected no pair",
                         out_addr, out_data);
            end else begin
                exp_pair = exp_q.pop_front();
                check("pair_addr", out_addr, exp_pair[36:32]);
                check("pair_data", out_data, exp_pair[31:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int cyc, fd, drop_at, n;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; out_ready = 1'b1;
        c_start = 1'b0; c_cont = 1'b0; c_ready = 1'b1;
        exp_fc = 0;

        // Reset, then idle with start low.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_addr", out_addr, 5'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_corner_debug_addr", c_debug_addr, 5'd7);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 1'b0);
            check("idle_out_valid", out_valid, 1'b0);
            check("idle_debug_addr", debug_addr, 5'd0);
            check("idle_frame_count", frame_count, 16'd0);
        end

        // Single frame, ready always high: frame_done in cycle 97.
        @(posedge clk); #1;
        push_frame();
        pulse_start();
        cyc = 1;
        while (!frame_done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("frame_done_cycle", cyc, 97);
        exp_fc++;
        @(posedge clk); #1;
        check("single_frame_count", frame_count, 16'(exp_fc));
        check("single_busy", busy, 1'b0);
        check("single_frame_done_pulse", frame_done, 1'b0);
        check("single_queue_empty", exp_q.size(), 0);

        // Backpressure on pair addr=3.
        push_frame();
        pulse_start();
        wait_pair(5'd3, "bp_reach_addr3");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_held", out_valid, 1'b1);
            check("bp_addr_held", out_addr, 5'd3);
            check("bp_data_held", out_data, 32'h1000_0003);
            check("bp_debug_addr", debug_addr, 5'd3);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle("bp_idle");
        exp_fc++;
        check("bp_frame_count", frame_count, 16'(exp_fc));
        check("bp_queue_empty", exp_q.size(), 0);

        // Continuous mode, dropped during frame 3, stray start mid-frame.
        for (int f = 0; f < 3; f++) push_frame();
        continuous = 1'b1;
        pulse_start();
        cyc = 0; fd = 0; drop_at = -1;
        while (busy && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (frame_done) begin
                fd++;
                if (fd == 2) drop_at = cyc + 10;
            end
            start = (cyc == 20);
            if (cyc == drop_at) continuous = 1'b0;
        end
        start = 1'b0;
        check("cont_busy_end", busy, 1'b0);
        check("cont_frame_done_pulses", fd, 3);
        exp_fc += 3;
        check("cont_frame_count", frame_count, 16'(exp_fc));
        check("cont_queue_empty", exp_q.size(), 0);

        // Reset while SEND holds pair addr=10.
        push_frame();
        pulse_start();
        wait_pair(5'd10, "rst_reach_addr10");
        rst = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_debug_addr", debug_addr, 5'd0);
        check("midrst_frame_count", frame_count, 16'd0);
        check("midrst_out_data", out_data, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        exp_fc = 0;
        @(posedge clk); #1;
        push_frame();
        pulse_start();
        check("restart_debug_addr", debug_addr, 5'd0);
        wait_idle("restart_idle");
        exp_fc++;
        check("restart_frame_count", frame_count, 16'(exp_fc));
        check("restart_queue_empty", exp_q.size(), 0);

        // Corner: FIRST=LAST=7, four settle cycles before capture.
        c_start = 1'b1;
        @(posedge clk); #1;
        c_start = 1'b0;
        check("corner_debug_addr", c_debug_addr, 5'd7);
        n = 0;
        while (!c_out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("corner_latency", n, 5);
        check("corner_out_addr", c_out_addr, 5'd7);
        check("corner_out_data", c_out_data, 32'h1000_0007);
        @(posedge clk); #1;
        check("corner_frame_done", c_frame_done, 1'b1);
        check("corner_valid_cleared", c_out_valid, 1'b0);
        @(posedge clk); #1;
        check("corner_busy", c_busy, 1'b0);
        check("corner_frame_count", c_frame_count, 16'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("corner_single_pair", c_out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
